// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32M iterative multiply/divide unit: funct3 decode,
// FSM state encoding and the fixed results of the divide corner cases.
package muldiv_pkg;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/muldiv_if.sv
// Core-side bundle of the multiply/divide unit: operation request from the
// register-file read ports and the result on the register-file write port.
interface muldiv_if #(
  parameter int unsigned XLEN = 32
);

  logic            start;
  logic [2:0]      funct3;
  logic [4:0]      rd;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            busy;
  logic            we;
  logic [4:0]      WriteAddr;
  logic [XLEN-1:0] WriteData;

  modport master (
    output start, funct3, rd, rs1_data, rs2_data,
    input  busy, we, WriteAddr, WriteData
  );

  modport slave (
    input  start, funct3, rd, rs1_data, rs2_data,
    output busy, we, WriteAddr, WriteData
  );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32-step shift-add multiply and restoring divide
// on operand magnitudes, sign fix-up in DONE, divide corner cases bypass CALC.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);

  logic [1:0]        state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              a_neg_q, a_neg_d;
  logic              b_neg_q, b_neg_d;
  logic              fast_q, fast_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;

  // Incoming operation decode
  logic            in_a_signed, in_b_signed, in_a_neg, in_b_neg;
  logic            in_div0, in_ovf, in_fast;
  logic [XLEN-1:0] in_a_mag, in_b_mag, fast_res;

  always_comb begin
    in_a_signed = (bus.funct3 == F_MULH) || (bus.funct3 == F_MULHSU) ||
                  (bus.funct3 == F_DIV)  || (bus.funct3 == F_REM);
    in_b_signed = (bus.funct3 == F_MULH) || (bus.funct3 == F_DIV) || (bus.funct3 == F_REM);
    in_a_neg    = in_a_signed && bus.rs1_data[XLEN-1];
    in_b_neg    = in_b_signed && bus.rs2_data[XLEN-1];
    in_a_mag    = in_a_neg ? -bus.rs1_data : bus.rs1_data;
    in_b_mag    = in_b_neg ? -bus.rs2_data : bus.rs2_data;
    in_div0     = bus.funct3[2] && (bus.rs2_data == '0);
    in_ovf      = ((bus.funct3 == F_DIV) || (bus.funct3 == F_REM)) &&
                  (bus.rs1_data == INT_MIN) && (bus.rs2_data == DIV0_Q);
    in_fast     = in_div0 || in_ovf;
    // funct3[1] separates REM/REMU from DIV/DIVU within the divide group
    if (in_div0) begin
      fast_res = bus.funct3[1] ? bus.rs1_data : DIV0_Q;
    end else begin
      fast_res = bus.funct3[1] ? '0 : INT_MIN;
    end
  end

  // One iteration of the shared datapath. Multiply keeps {hi, multiplier} in acc and
  // shifts right; divide keeps {remainder, dividend/quotient} and shifts left.
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic              div_borrow;
  logic [XLEN-1:0]   div_trial;
  logic [2*XLEN-1:0] iter_acc;

  always_comb begin
    mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_shift  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_borrow = div_shift < {1'b0, b_q};
    // Only consumed when no borrow, where the true difference fits in XLEN bits
    div_trial  = div_shift[XLEN-1:0] - b_q;
    if (op_q[2]) begin
      if (div_borrow) begin
        iter_acc = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end else begin
        iter_acc = {div_trial, acc_q[XLEN-2:0], 1'b1};
      end
    end else begin
      iter_acc = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  // Sign fix-up of the finished magnitude result
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem, quot_fix, rem_fix, res_fix;

  always_comb begin
    prod     = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
    quot     = acc_q[XLEN-1:0];
    rem      = acc_q[2*XLEN-1:XLEN];
    quot_fix = (a_neg_q ^ b_neg_q) ? -quot : quot;
    rem_fix  = a_neg_q ? -rem : rem;
    case (op_q)
      F_MUL:                     res_fix = prod[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU: res_fix = prod[2*XLEN-1:XLEN];
      F_DIV, F_DIVU:             res_fix = quot_fix;
      default:                   res_fix = rem_fix;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    b_d     = b_q;
    acc_d   = acc_q;
    a_neg_d = a_neg_q;
    b_neg_d = b_neg_q;
    fast_d  = fast_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d    = bus.funct3;
          rd_d    = bus.rd;
          b_d     = in_b_mag;
          acc_d   = {{XLEN{1'b0}}, in_a_mag};
          a_neg_d = in_a_neg;
          b_neg_d = in_b_neg;
          cnt_d   = '0;
          fast_d  = in_fast;
          if (in_fast) begin
            wdata_d = fast_res;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = iter_acc;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!fast_q) begin
          wdata_d = res_fix;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      fast_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
      fast_q  <= fast_d;
      wdata_q <= wdata_d;
    end
  end

  // In a normal DONE cycle the fixed-up result is shown straight from the datapath
  // and captured into wdata_q so it holds until the next DONE.
  always_comb begin
    bus.busy      = (state_q != S_IDLE);
    bus.we        = (state_q == S_DONE) && (rd_q != 5'd0);
    bus.WriteAddr = rd_q;
    bus.WriteData = ((state_q == S_DONE) && !fast_q) ? res_fix : wdata_q;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: expected writes are queued when an operation
// is issued and popped when the unit raises we.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  muldiv_if #(.XLEN(32)) mif ();

  muldiv_unit #(.XLEN(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (mif)
  );

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   we_cnt      = 0;

  always @(negedge clk) if (mif.we) we_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa64, sb64, ub64;
    logic signed [31:0] sa, sbv;
    logic [63:0]        p;
    sa64 = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    ub64 = {32'd0, b};
    sa   = a;
    sbv  = b;
    case (f3)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = sa64 * sb64; return p[63:32]; end
      3'd2: begin p = sa64 * ub64; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sbv;
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sbv;
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b);
    if (f3[2] && (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 0;
    return 32;
  endfunction

  // Called at a negedge; drives one accept cycle and returns at the next negedge (n=0).
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    exp_t e;
    mif.start    = 1'b1;
    mif.funct3   = f3;
    mif.rd       = rd;
    mif.rs1_data = a;
    mif.rs2_data = b;
    if (rd != 5'd0) begin
      e.rd   = rd;
      e.data = ref_result(f3, a, b);
      sb.push_back(e);
    end
    @(negedge clk);
    mif.start    = 1'b0;
    mif.funct3   = 3'($urandom_range(0, 7));
    mif.rd       = 5'($urandom_range(1, 31));
    mif.rs1_data = $urandom;
    mif.rs2_data = $urandom;
  endtask

  // Steps negedges until we is seen; lat = cycles waited, -1 if the bound expires.
  task automatic wait_we(output int lat);
    lat = -1;
    for (int n = 0; n <= 40; n++) begin
      if (mif.we) begin
        lat = n;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst          = 1'b0;
    mif.start    = 1'b0;
    mif.funct3   = '0;
    mif.rd       = '0;
    mif.rs1_data = '0;
    mif.rs2_data = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if (mif.busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy got %b want 0", mif.busy);
    end
    vectors++;
    if (mif.we !== 1'b0) begin
      miscompares++; $display("FAIL reset_we got %b want 0", mif.we);
    end
    vectors++;
    if (mif.WriteAddr !== 5'd0) begin
      miscompares++; $display("FAIL reset_waddr got %h want 0", mif.WriteAddr);
    end
    vectors++;
    if (mif.WriteData !== 32'd0) begin
      miscompares++; $display("FAIL reset_wdata got %h want 0", mif.WriteData);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul_basic;
    int   lat, w0;
    exp_t e;
    w0 = we_cnt;
    issue(F_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5);
    wait_we(lat);
    if (sb.size() > 0) e = sb.pop_front();
    vectors++;
    if (lat !== 32) begin
      miscompares++; $display("FAIL mul_latency got %0d want 32", lat);
    end
    vectors++;
    if (mif.WriteAddr !== 5'd5 || mif.WriteData !== 32'hFFFF_FFEB) begin
      miscompares++;
      $display("FAIL mul_result got %h/%h want 05/ffffffeb", mif.WriteAddr, mif.WriteData);
    end
    vectors++;
    if (mif.busy !== 1'b1) begin
      miscompares++; $display("FAIL mul_busy_done got %b want 1", mif.busy);
    end
    @(negedge clk);
    vectors++;
    if (mif.busy !== 1'b0 || mif.we !== 1'b0) begin
      miscompares++; $display("FAIL mul_busy_fall got %b/%b want 0/0", mif.busy, mif.we);
    end
    vectors++;
    if (we_cnt - w0 !== 1) begin
      miscompares++; $display("FAIL mul_we_pulses got %0d want 1", we_cnt - w0);
    end
  endtask

  task automatic run_table(input string name, input logic [2:0] f3s[],
                           input logic [31:0] as[], input logic [31:0] bs[]);
    int   lat, want;
    exp_t e;
    for (int i = 0; i < f3s.size(); i++) begin
      want = exp_lat(f3s[i], as[i], bs[i]);
      issue(f3s[i], as[i], bs[i], 5'(i + 1));
      wait_we(lat);
      if (sb.size() > 0) e = sb.pop_front();
      vectors++;
      if (lat !== want) begin
        miscompares++;
        $display("FAIL %s_lat[%0d] got %0d want %0d", name, i, lat, want);
      end
      if (lat >= 0) begin
        vectors++;
        if (mif.WriteAddr !== e.rd || mif.WriteData !== e.data) begin
          miscompares++;
          $display("FAIL %s_data[%0d] f3=%0d a=%h b=%h got %h/%h want %h/%h", name, i,
                   f3s[i], as[i], bs[i], mif.WriteAddr, mif.WriteData, e.rd, e.data);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mul_variants;
    logic [2:0]  f3s[] = new[8];
    logic [31:0] as[]  = new[8];
    logic [31:0] bs[]  = new[8];
    f3s[0] = F_MULHU;  as[0] = 32'hFFFF_FFFF; bs[0] = 32'hFFFF_FFFF;
    f3s[1] = F_MULH;   as[1] = 32'hFFFF_FFFF; bs[1] = 32'hFFFF_FFFF;
    f3s[2] = F_MULHSU; as[2] = 32'hFFFF_FFFF; bs[2] = 32'd2;
    f3s[3] = F_MULH;   as[3] = 32'h8000_0000; bs[3] = 32'h8000_0000;
    for (int i = 4; i < 8; i++) begin
      f3s[i] = 3'($urandom_range(0, 3));
      as[i]  = $urandom;
      bs[i]  = $urandom;
    end
    run_table("mul", f3s, as, bs);
  endtask

  task automatic test_div;
    logic [2:0]  f3s[] = new[9];
    logic [31:0] as[]  = new[9];
    logic [31:0] bs[]  = new[9];
    f3s[0] = F_DIV;  as[0] = 32'hFFFF_FFF9; bs[0] = 32'd2;
    f3s[1] = F_REM;  as[1] = 32'hFFFF_FFF9; bs[1] = 32'd2;
    f3s[2] = F_DIVU; as[2] = 32'd100;       bs[2] = 32'd7;
    f3s[3] = F_REMU; as[3] = 32'd100;       bs[3] = 32'd7;
    f3s[4] = F_DIVU; as[4] = 32'hFFFF_FFFF; bs[4] = 32'h8000_0001;
    for (int i = 5; i < 9; i++) begin
      f3s[i] = 3'($urandom_range(4, 7));
      as[i]  = $urandom;
      bs[i]  = $urandom_range(1, 32'hFFFF);
      if (i[0]) bs[i] = -bs[i];
    end
    run_table("div", f3s, as, bs);
  endtask

  task automatic test_fast;
    logic [2:0]  f3s[] = new[6];
    logic [31:0] as[]  = new[6];
    logic [31:0] bs[]  = new[6];
    f3s[0] = F_DIVU; as[0] = 32'h1234;      bs[0] = 32'd0;
    f3s[1] = F_REM;  as[1] = 32'h1234;      bs[1] = 32'd0;
    f3s[2] = F_DIV;  as[2] = 32'h8000_0000; bs[2] = 32'hFFFF_FFFF;
    f3s[3] = F_REM;  as[3] = 32'h8000_0000; bs[3] = 32'hFFFF_FFFF;
    f3s[4] = F_DIV;  as[4] = 32'hDEAD_BEEF; bs[4] = 32'd0;
    f3s[5] = F_REMU; as[5] = 32'hCAFE_0001; bs[5] = 32'd0;
    run_table("fast", f3s, as, bs);
  endtask

  task automatic test_reset_abort;
    int   lat, w0;
    exp_t e;
    issue(F_MUL, 32'h0001_0003, 32'h0000_0101, 5'd7);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    vectors++;
    if (mif.busy !== 1'b0 || mif.we !== 1'b0) begin
      miscompares++; $display("FAIL abort_outputs got %b/%b want 0/0", mif.busy, mif.we);
    end
    if (sb.size() > 0) e = sb.pop_back();
    w0 = we_cnt;
    @(negedge clk);
    rst = 1'b1;
    issue(F_DIVU, 32'd1000, 32'd9, 5'd12);
    wait_we(lat);
    if (sb.size() > 0) e = sb.pop_front();
    vectors++;
    if (lat !== 32) begin
      miscompares++; $display("FAIL abort_restart_lat got %0d want 32", lat);
    end
    vectors++;
    if (mif.WriteAddr !== e.rd || mif.WriteData !== e.data) begin
      miscompares++;
      $display("FAIL abort_restart_data got %h/%h want %h/%h", mif.WriteAddr, mif.WriteData,
               e.rd, e.data);
    end
    @(negedge clk);
    vectors++;
    if (we_cnt - w0 !== 1) begin
      miscompares++; $display("FAIL abort_we_pulses got %0d want 1", we_cnt - w0);
    end
  endtask

  task automatic test_busy_ignore;
    int   lat, w0;
    exp_t e;
    w0 = we_cnt;
    issue(F_DIV, 32'd1000, 32'hFFFF_FFFD, 5'd3);
    repeat (4) @(negedge clk);
    mif.start    = 1'b1;
    mif.funct3   = F_MUL;
    mif.rd       = 5'd9;
    mif.rs1_data = 32'd5;
    mif.rs2_data = 32'd6;
    @(negedge clk);
    mif.start = 1'b0;
    wait_we(lat);
    if (sb.size() > 0) e = sb.pop_front();
    vectors++;
    if (lat + 5 !== 32) begin
      miscompares++; $display("FAIL ignore_lat got %0d want 32", lat + 5);
    end
    vectors++;
    if (mif.WriteAddr !== e.rd || mif.WriteData !== e.data) begin
      miscompares++;
      $display("FAIL ignore_data got %h/%h want %h/%h", mif.WriteAddr, mif.WriteData,
               e.rd, e.data);
    end
    repeat (40) @(negedge clk);
    vectors++;
    if (we_cnt - w0 !== 1) begin
      miscompares++; $display("FAIL ignore_we_pulses got %0d want 1", we_cnt - w0);
    end
  endtask

  task automatic test_rd_zero;
    int w0, bc;
    w0 = we_cnt;
    bc = 0;
    issue(F_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0);
    for (int n = 0; n < 40; n++) begin
      if (mif.busy) bc++;
      @(negedge clk);
    end
    vectors++;
    if (bc !== 33) begin
      miscompares++; $display("FAIL rd0_busy_cycles got %0d want 33", bc);
    end
    vectors++;
    if (we_cnt - w0 !== 0) begin
      miscompares++; $display("FAIL rd0_we_pulses got %0d want 0", we_cnt - w0);
    end
  endtask

  task automatic test_back_to_back;
    int   lat;
    exp_t e;
    issue(F_REMU, 32'hFFFF_FFF0, 32'd13, 5'd20);
    wait_we(lat);
    if (sb.size() > 0) e = sb.pop_front();
    vectors++;
    if (lat !== 32 || mif.WriteData !== e.data) begin
      miscompares++;
      $display("FAIL b2b_first got lat %0d data %h want lat 32 data %h", lat, mif.WriteData,
               e.data);
    end
    @(negedge clk);
    vectors++;
    if (mif.WriteData !== e.data) begin
      miscompares++; $display("FAIL b2b_hold got %h want %h", mif.WriteData, e.data);
    end
    issue(F_DIVU, 32'h55, 32'd0, 5'd21);
    wait_we(lat);
    if (sb.size() > 0) e = sb.pop_front();
    vectors++;
    if (lat !== 0 || mif.WriteData !== e.data) begin
      miscompares++;
      $display("FAIL b2b_fast got lat %0d data %h want lat 0 data %h", lat, mif.WriteData,
               e.data);
    end
    @(negedge clk);
    issue(F_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd22);
    wait_we(lat);
    if (sb.size() > 0) e = sb.pop_front();
    vectors++;
    if (lat !== 32 || mif.WriteData !== e.data) begin
      miscompares++;
      $display("FAIL b2b_after_fast got lat %0d data %h want lat 32 data %h", lat,
               mif.WriteData, e.data);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_mul_variants();
    test_div();
    test_fast();
    test_reset_abort();
    test_busy_ignore();
    test_rd_zero();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multi-cycle multiply/divide unit for the RV32M extension. It sits between the register file's read and write ports. It consumes the two source-operand read values and the destination index. It returns one result through the register-file write port (`we`/`WriteAddr`/`WriteData`) after a fixed latency. The core stalls on `busy`.

## Interface
- `XLEN`, default 32, operand and result width; only 32 is supported.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-low reset; clears all state immediately.
- `start` input 1: request a new operation; sampled only in IDLE.
- `funct3` input 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rd` input 5: destination register index.
- `rs1_data` input XLEN: operand A (register-file ReadData1).
- `rs2_data` input XLEN: operand B (register-file ReadData2).
- `busy` output 1: high in every state except IDLE.
- `we` output 1: register-file write enable; one-cycle pulse.
- `WriteAddr` output 5: latched `rd`.
- `WriteData` output XLEN: result.

## Operation
- States:
  - IDLE → CALC when `start` is high and the operation is not a fast case.
  - IDLE → DONE when `start` is high and the operation is a fast case.
  - CALC → DONE when the iteration counter reaches 31.
  - DONE → IDLE unconditionally.
- On accept, latch `funct3`, `rd`, operands and sign flags:
  - MULH and DIV/REM: A and B signed.
  - MULHSU: A signed, B unsigned.
  - All others: unsigned.
- Signed operands are converted to magnitude. The result sign is applied in DONE.
  - Product: negate if the operand signs differ.
  - Quotient: negate if the signs differ.
  - Remainder: takes the sign of the dividend.
- Multiply: radix-2 shift-add, 32 iterations, 64-bit accumulator. MUL returns bits [31:0]; the MULH variants return bits [63:32] after sign fix.
- Divide: restoring algorithm, 32 iterations. Quotient and remainder registers are each 32 bits, plus a 33-bit trial subtract.
- Fast cases (no CALC):
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return the dividend.
  - Signed overflow, 0x80000000 / 0xFFFFFFFF: DIV returns 0x80000000; REM returns 0.
- `start` while `busy` is ignored; no queueing.
- `rd` == 0: the operation runs normally, but `we` stays 0 in DONE.
- `we` = (state == DONE) && (WriteAddr != 0). `WriteData` holds its value until the next DONE.
- Reset mid-operation aborts with no write; the partial result is discarded.

## Timing
- Reset values: state IDLE; `busy` 0, `we` 0, `WriteAddr` 0, `WriteData` 0; counter 0.
- Accept edge E0: `start` is high with state IDLE.
- Normal operation:
  - CALC is active from E0 through E32.
  - DONE is active between E32 and E33, with `we` high and `WriteData` valid in that cycle.
  - The register file captures the result at E33.
- Fast case: DONE is active between E0 and E1; the register file captures at E1.
- `busy` is high from just after E0 until E33 (normal) or E1 (fast).
- Earliest next accept: E34 (normal) or E2 (fast).
- Operands only need to be valid at E0; later changes on `rs1_data`/`rs2_data` are ignored.
- Every output is a function of registered state only; no input-to-output combinational path.

## Structure
- Package `muldiv_pkg`:
  - `funct3` localparams: F_MUL … F_REMU.
  - State encoding: S_IDLE, S_CALC, S_DONE.
  - Constants DIV0_Q = 32'hFFFFFFFF and INT_MIN = 32'h80000000.
- Single module: one FSM plus a shared shift/add-subtract datapath, with a 5-bit iteration counter. No sub-module.

## Test plan
- MUL, A = 7, B = 0xFFFFFFFD, `rd` = 5 → `we` = 1 only in the cycle after E32; WriteAddr 5, WriteData 0xFFFFFFEB; `busy` falls at E33.
- MULHU, A = B = 0xFFFFFFFF → WriteData 0xFFFFFFFE. MULH with the same inputs → 0x00000000. MULHSU, A = 0xFFFFFFFF, B = 2 → 0xFFFFFFFF.
- DIV, A = 0xFFFFFFF9 (−7), B = 2 → 0xFFFFFFFD. REM on the same inputs → 0xFFFFFFFF. DIVU, A = 100, B = 7 → 14. REMU on the same inputs → 2.
- Fast cases, each completing with `we` at E0+1 cycle:
  - DIVU, A = 0x1234, B = 0 → 0xFFFFFFFF.
  - REM, A = 0x1234, B = 0 → 0x1234.
  - DIV, A = 0x80000000, B = 0xFFFFFFFF → 0x80000000.
- `rst` low at E10 of a MUL → `busy` and `we` are 0 immediately, and no `we` pulse follows. After release, a new `start` is accepted on the first edge.
- `start` pulsed at E5 during a DIV → ignored; exactly one `we` pulse at E32. Separately, `rd` = 0 → `busy` runs the full 33 cycles with no `we` pulse.
